// File: rtl/dim_zone_scheduler_if.sv
// Bus between the zone-mean producer, the scheduler and the backlight driver.
// The scheduler takes the slave side; the driving environment takes the master side.
interface dim_zone_scheduler_if;
    logic       vs;
    logic [7:0] mean_i;
    logic       mean_valid_i;
    logic [7:0] zone_data_o;
    logic [6:0] zone_addr_o;
    logic       zone_valid_o;
    logic       zone_ready_i;
    logic       frame_done_o;
    logic       frame_drop_o;
    logic       overflow_o;

    modport slave (
        input  vs, mean_i, mean_valid_i, zone_ready_i,
        output zone_data_o, zone_addr_o, zone_valid_o,
        output frame_done_o, frame_drop_o, overflow_o
    );

    modport master (
        output vs, mean_i, mean_valid_i, zone_ready_i,
        input  zone_data_o, zone_addr_o, zone_valid_o,
        input  frame_done_o, frame_drop_o, overflow_o
    );
endinterface

// File: rtl/dim_zone_scheduler.sv
// Ping-pong buffered local-dimming zone scheduler: collects one frame of zone means,
// swaps banks on frame sync and streams the completed frame to the backlight driver.
module dim_zone_scheduler #(
    parameter int unsigned ZONE_H = 16,
    parameter int unsigned ZONE_V = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dim_zone_scheduler_if.slave  bus
);
    localparam int unsigned ZONE_NUM = ZONE_H * ZONE_V;
    localparam int unsigned AW       = 7;
    localparam int unsigned CW       = 8;
    localparam int unsigned DW       = 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(ZONE_NUM - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(ZONE_NUM);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t        state;
    logic [DW-1:0] bank_mem [2][ZONE_NUM];
    logic          wr_bank;
    logic          rd_bank;
    logic          vs_d;
    logic [CW-1:0] wr_cnt;
    logic          vs_edge;
    logic          swap;
    logic          wr_en;
    logic          wr_bank_eff;
    logic [AW-1:0] wr_addr;

    assign vs_edge     = bus.vs & ~vs_d;
    assign swap        = vs_edge && (wr_cnt == FULL_CNT) && (state == IDLE);
    assign rd_bank     = ~wr_bank;
    // A mean arriving with the frame edge belongs to the new frame, in the post-swap bank.
    assign wr_bank_eff = swap ? ~wr_bank : wr_bank;
    assign wr_addr     = vs_edge ? '0 : AW'(wr_cnt);
    assign wr_en       = bus.mean_valid_i && (vs_edge || (wr_cnt != FULL_CNT));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_mem[wr_bank_eff][wr_addr] <= bus.mean_i;
        end
    end

    // Write side: frame edge detection, fill counter, bank ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d             <= 1'b0;
            wr_cnt           <= '0;
            wr_bank          <= 1'b0;
            bus.overflow_o   <= 1'b0;
            bus.frame_drop_o <= 1'b0;
        end else begin
            vs_d             <= bus.vs;
            bus.frame_drop_o <= vs_edge & ~swap;
            if (swap) begin
                wr_bank <= ~wr_bank;
            end
            if (vs_edge) begin
                wr_cnt <= bus.mean_valid_i ? CW'(1) : '0;
            end else if (bus.mean_valid_i) begin
                if (wr_cnt != FULL_CNT) begin
                    wr_cnt <= wr_cnt + CW'(1);
                end else begin
                    bus.overflow_o <= 1'b1;
                end
            end
        end
    end

    // Read side: the output register is the synchronous RAM read port, so the next
    // address is fetched on the transfer cycle and data stays put while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            bus.zone_valid_o <= 1'b0;
            bus.zone_data_o  <= '0;
            bus.zone_addr_o  <= '0;
            bus.frame_done_o <= 1'b0;
        end else begin
            bus.frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    bus.zone_valid_o <= 1'b0;
                    bus.zone_addr_o  <= '0;
                    if (swap) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.zone_valid_o) begin
                        bus.zone_valid_o <= 1'b1;
                        bus.zone_data_o  <= bank_mem[rd_bank][bus.zone_addr_o];
                    end else if (bus.zone_ready_i) begin
                        if (bus.zone_addr_o == LAST_ADDR) begin
                            state            <= DONE;
                            bus.zone_valid_o <= 1'b0;
                            bus.zone_addr_o  <= '0;
                            bus.frame_done_o <= 1'b1;
                        end else begin
                            bus.zone_addr_o <= bus.zone_addr_o + AW'(1);
                            bus.zone_data_o <= bank_mem[rd_bank][bus.zone_addr_o + AW'(1)];
                        end
                    end
                end
                DONE: begin
                    bus.zone_valid_o <= 1'b0;
                    state            <= IDLE;
                end
                default: begin
                    bus.zone_valid_o <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/dim_zone_scheduler.md
DIM_ZONE_SCHEDULER -- requirements
Module: dim_zone_scheduler

Interface
REQ-001 SHALL have parameter ZONE_H, default 16, zones per row.
REQ-002 SHALL have parameter ZONE_V, default 8, zone rows; ZONE_NUM = ZONE_H*ZONE_V, max 128.
REQ-003 SHALL have port clk  input  1  pixel clock; only clock.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port vs  input  1  frame sync, active-high; frame boundary = rising edge.
REQ-006 SHALL have port mean_i  input  8  gamma-fixed zone mean, raster zone order.
REQ-007 SHALL have port mean_valid_i  input  1  mean_i valid this cycle.
REQ-008 SHALL have port zone_data_o  output  8  zone value to backlight driver.
REQ-009 SHALL have port zone_addr_o  output  7  zone index of zone_data_o.
REQ-010 SHALL have port zone_valid_o  output  1  zone_data_o/zone_addr_o valid.
REQ-011 SHALL have port zone_ready_i  input  1  driver accepts; transfer = valid & ready.
REQ-012 SHALL have port frame_done_o  output  1  one-cycle pulse after last zone transfer.
REQ-013 SHALL have port frame_drop_o  output  1  one-cycle pulse when a frame is discarded.
REQ-014 SHALL have port overflow_o  output  1  sticky: more than ZONE_NUM means in one frame.

Function
REQ-015 SHALL hold two ZONE_NUM x 8 banks (ping-pong): one write bank, one read bank.
REQ-016 SHALL write mean_i to write bank at wr_cnt on each mean_valid_i, then increment wr_cnt.
REQ-017 SHALL ignore mean_valid_i when wr_cnt == ZONE_NUM and set overflow_o, held until reset.
REQ-018 SHALL detect vs rising edge with one register stage (vs_d); edge = vs & ~vs_d.
REQ-019 On vs edge with wr_cnt == ZONE_NUM and FSM IDLE, SHALL swap banks and enter SEND next cycle.
REQ-020 On vs edge with wr_cnt != ZONE_NUM, SHALL not swap, SHALL pulse frame_drop_o, read bank keeps previous frame.
REQ-021 On vs edge while FSM not IDLE, SHALL not swap and SHALL pulse frame_drop_o.
REQ-022 SHALL clear wr_cnt to 0 on every vs edge; a same-cycle mean_valid_i is written at address 0 of the (post-swap) write bank, wr_cnt becomes 1.
REQ-023 FSM states: IDLE, SEND, DONE; IDLE->SEND on accepted swap; SEND->DONE on transfer of index ZONE_NUM-1; DONE->IDLE unconditionally after one cycle.
REQ-024 In SEND, SHALL present zones 0..ZONE_NUM-1 in order; rd index advances only on transfer.
REQ-025 zone_data_o, zone_addr_o SHALL stay stable while zone_valid_o & ~zone_ready_i.
REQ-026 First zone_valid_o SHALL assert no later than 2 cycles after SEND entry; with zone_ready_i held high, one transfer per cycle thereafter (synchronous-read RAM plus output register/skid).
REQ-027 zone_valid_o SHALL be 0 in IDLE and DONE.
REQ-028 frame_done_o SHALL be high exactly during DONE.
REQ-029 Read bank SHALL not be written while in SEND.
REQ-030 frame_drop_o and frame_done_o MAY coincide; each reports independently.

Reset
REQ-031 rst high SHALL asynchronously force: FSM IDLE, wr_cnt 0, rd index 0, write bank 0, vs_d 0, zone_valid_o 0, zone_data_o 0, zone_addr_o 0, frame_done_o 0, frame_drop_o 0, overflow_o 0.
REQ-032 Bank contents need not be reset; no zone_valid_o before first complete frame swap.
REQ-033 Reset mid-SEND SHALL abort the stream; no frame_done_o for the aborted frame.

Verification (ZONE_H=16, ZONE_V=8)
REQ-034 128 means value k (k=0..127), vs edge, ready=1 -> 128 transfers addr k data k, consecutive cycles, then one frame_done_o.
REQ-035 Same frame, ready toggling 1/0 every cycle -> 128 transfers in order, outputs stable during stalls, no duplicates.
REQ-036 Frame of 100 means then vs edge -> frame_drop_o pulse, no zone_valid_o; next full frame streams normally.
REQ-037 130 means then vs edge -> overflow_o=1 sticky, first 128 values streamed, last 2 discarded.
REQ-038 Second full frame's vs edge while first still in SEND (ready=0) -> frame_drop_o pulse, first stream completes unchanged.
REQ-039 rst asserted after 50 transfers -> all outputs 0 immediately; next full frame streams from addr 0.
